// File: rtl/rtype_imem_writer_pkg.sv
// ============================================================================
// rv_pkg : RV32I opcode/funct constants, ALUSel codes and writer state enum
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OPCODE_OP  = 7'h33;
  localparam logic [6:0] FUNCT7_ALT = 7'h20;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/rtype_imem_writer_if.sv
// ============================================================================
// rtype_imem_writer_if : operation stream in, instruction-memory write bus out
// Rev 1.0
// ============================================================================
`default_nettype none

interface rtype_imem_writer_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_alu_sel;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_alu_sel, in_rd, in_rs1, in_rs2, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_alu_sel, in_rd, in_rs1, in_rs2, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/rtype_imem_writer_encode.sv
// ============================================================================
// rtype_encode : ALUSel + rd/rs1/rs2 -> RV32I R-type word, with legal flag
// Rev 1.0
// ============================================================================
`default_nettype none

module rtype_encode
  import rv_pkg::*;
(
  input  logic [3:0]  alu_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] word,
  output logic        legal
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  always_comb begin
    funct7 = 7'h00;
    funct3 = 3'd0;
    legal  = 1'b1;
    case (alu_sel)
      ALU_ADD:  funct3 = 3'd0;
      ALU_SUB:  funct7 = FUNCT7_ALT;
      ALU_SLL:  funct3 = 3'd1;
      ALU_SLT:  funct3 = 3'd2;
      ALU_SLTU: funct3 = 3'd3;
      ALU_XOR:  funct3 = 3'd4;
      ALU_SRL:  funct3 = 3'd5;
      ALU_SRA: begin
        funct7 = FUNCT7_ALT;
        funct3 = 3'd5;
      end
      ALU_OR:   funct3 = 3'd6;
      ALU_AND:  funct3 = 3'd7;
      default:  legal  = 1'b0;
    endcase
  end

  assign word = {funct7, rs2, rs1, funct3, rd, OPCODE_OP};

endmodule

`default_nettype wire

// File: rtl/rtype_imem_writer.sv
// ============================================================================
// rtype_imem_writer : encodes an ALU-op stream and fills imem from address 0
// Rev 1.0
// ============================================================================
`default_nettype none

module rtype_imem_writer
  import rv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  rtype_imem_writer_if.slave bus,
  output logic            busy,
  output logic            done,
  output logic [ADDR_W:0] count,
  output logic            err
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  wr_state_t         state;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              at_top;

  rtype_encode u_encode (
    .alu_sel (bus.in_alu_sel),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .word    (enc_word),
    .legal   (enc_legal)
  );

  // Words written so far is also the next free address.
  assign next_addr    = count[ADDR_W-1:0];
  assign at_top       = (next_addr == TOP_ADDR);
  assign bus.in_ready = (state == RUN) && !count[ADDR_W];
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            count <= '0;
            err   <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (enc_legal) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= next_addr;
              bus.imem_wdata <= enc_word;
              count          <= count + 1'b1;
              // Writing the top word ends the load; no wrap to address 0.
              if (bus.in_last || at_top) begin
                state <= DONE;
                done  <= 1'b1;
              end
              if (!bus.in_last && at_top) begin
                err <= 1'b1;
              end
            end else begin
              err <= 1'b1;
              if (bus.in_last) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtype_imem_writer.sv
// ============================================================================
// tb_rtype_imem_writer : two writers (ADDR_W 8 and 2) on one stimulus stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rtype_imem_writer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_last;
  logic [3:0] in_alu_sel;
  logic [4:0] in_rd, in_rs1, in_rs2;

  logic       busy8, done8, err8;
  logic [8:0] count8;
  logic       busy2, done2, err2;
  logic [2:0] count2;

  int errors = 0;
  int checks = 0;

  rtype_imem_writer_if #(.ADDR_W(8)) bus8 ();
  rtype_imem_writer_if #(.ADDR_W(2)) bus2 ();

  assign bus8.in_valid   = in_valid;
  assign bus8.in_alu_sel = in_alu_sel;
  assign bus8.in_rd      = in_rd;
  assign bus8.in_rs1     = in_rs1;
  assign bus8.in_rs2     = in_rs2;
  assign bus8.in_last    = in_last;
  assign bus2.in_valid   = in_valid;
  assign bus2.in_alu_sel = in_alu_sel;
  assign bus2.in_rd      = in_rd;
  assign bus2.in_rs1     = in_rs1;
  assign bus2.in_rs2     = in_rs2;
  assign bus2.in_last    = in_last;

  rtype_imem_writer #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus8.slave),
    .busy(busy8), .done(done8), .count(count8), .err(err8)
  );

  rtype_imem_writer #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus2.slave),
    .busy(busy2), .done(done2), .count(count2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 loading, 2 completion cycle
  int          CAP [2] = '{256, 4};
  int          F7  [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  int          F3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int          m_st [2], m_cnt [2], m_err [2], m_we [2], m_done [2], m_addr [2];
  logic [31:0] m_wd [2];
  logic [31:0] mem8 [256];

  function automatic logic [31:0] enc(int sel, int rd, int rs1, int rs2);
    return 32'(F7[sel] * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
               + F3[sel] * (1 << 12) + rd * (1 << 7) + 51);
  endfunction

  function automatic int dec(logic [31:0] w);
    if (w[6:0] != 7'h33) return 15;
    case ({w[31:25], w[14:12]})
      {7'h00, 3'd0}: return 0;
      {7'h20, 3'd0}: return 1;
      {7'h00, 3'd1}: return 2;
      {7'h00, 3'd2}: return 3;
      {7'h00, 3'd3}: return 4;
      {7'h00, 3'd4}: return 5;
      {7'h00, 3'd5}: return 6;
      {7'h20, 3'd5}: return 7;
      {7'h00, 3'd6}: return 8;
      {7'h00, 3'd7}: return 9;
      default:       return 15;
    endcase
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      m_we[m]   = 0;
      m_done[m] = 0;
      if (!rst_n) begin
        m_st[m] = 0; m_cnt[m] = 0; m_err[m] = 0; m_addr[m] = 0; m_wd[m] = 0;
      end else if (m_st[m] == 0) begin
        if (start) begin
          m_st[m] = 1; m_cnt[m] = 0; m_err[m] = 0;
        end
      end else if (m_st[m] == 1) begin
        if (in_valid) begin
          if (int'(in_alu_sel) < 10) begin
            m_we[m]   = 1;
            m_addr[m] = m_cnt[m];
            m_wd[m]   = enc(int'(in_alu_sel), int'(in_rd), int'(in_rs1), int'(in_rs2));
            m_cnt[m]  = m_cnt[m] + 1;
            if (in_last || m_cnt[m] == CAP[m]) begin
              m_st[m] = 2; m_done[m] = 1;
              if (!in_last) m_err[m] = 1;
            end
          end else begin
            m_err[m] = 1;
            if (in_last) begin
              m_st[m] = 2; m_done[m] = 1;
            end
          end
        end
      end else begin
        m_st[m] = 0;
      end
    end
  endtask

  task automatic chk(string name, int m, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
    end
  endtask

  task automatic compare_one(int m, logic we, int addr, logic [31:0] wd, logic rdy,
                             logic bsy, logic dn, int cnt, logic er);
    chk("imem_we", m, 32'(we), 32'(m_we[m]));
    chk("imem_addr", m, 32'(addr), 32'(m_addr[m]));
    chk("imem_wdata", m, wd, m_wd[m]);
    chk("in_ready", m, 32'(rdy), 32'(m_st[m] == 1));
    chk("busy", m, 32'(bsy), 32'(m_st[m] != 0));
    chk("done", m, 32'(dn), 32'(m_done[m]));
    chk("count", m, 32'(cnt), 32'(m_cnt[m]));
    chk("err", m, 32'(er), 32'(m_err[m]));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare_one(0, bus8.imem_we, int'(bus8.imem_addr), bus8.imem_wdata, bus8.in_ready,
                busy8, done8, int'(count8), err8);
    compare_one(1, bus2.imem_we, int'(bus2.imem_addr), bus2.imem_wdata, bus2.in_ready,
                busy2, done2, int'(count2), err2);
    if (bus8.imem_we === 1'b1) mem8[bus8.imem_addr] = bus8.imem_wdata;
  end

  task automatic idle(int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(int sel, int rd, int rs1, int rs2, bit last);
    in_valid   = 1'b1;
    in_alu_sel = 4'(sel);
    in_rd      = 5'(rd);
    in_rs1     = 5'(rs1);
    in_rs2     = 5'(rs2);
    in_last    = last;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_alu_sel = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    idle(2);
    chk("rst_busy", 0, 32'(busy8), 32'd0);
    chk("rst_count", 0, 32'(count8), 32'd0);
    chk("rst_we", 0, 32'(bus8.imem_we), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Two-word program
    pulse_start();
    beat(0, 1, 2, 3, 0);
    beat(1, 4, 5, 6, 1);
    chk("t1_done", 0, 32'(done8), 32'd1);
    chk("t1_we", 0, 32'(bus8.imem_we), 32'd1);
    chk("t1_addr", 0, 32'(bus8.imem_addr), 32'd1);
    chk("t1_count", 0, 32'(count8), 32'd2);
    chk("t1_err", 0, 32'(err8), 32'd0);
    idle(2);
    chk("t1_mem0", 0, mem8[0], 32'h003100B3);
    chk("t1_mem1", 0, mem8[1], 32'h40628233);

    // Extreme register indices
    pulse_start();
    beat(7, 31, 31, 31, 0);
    beat(9, 0, 0, 0, 1);
    idle(2);
    chk("t2_mem0", 0, mem8[0], 32'h41FFDFB3);
    chk("t2_mem1", 0, mem8[1], 32'h00007033);

    // All ALUSel codes, decoded back
    pulse_start();
    for (int s = 0; s < 10; s++) beat(s, s + 1, s + 2, s + 3, s == 9);
    idle(2);
    for (int s = 0; s < 10; s++) begin
      chk("sweep_dec", 0, 32'(dec(mem8[s])), 32'(s));
      chk("sweep_rd", 0, 32'(mem8[s][11:7]), 32'(s + 1));
    end

    // Illegal code in the middle
    pulse_start();
    beat(0, 1, 1, 1, 0);
    beat(12, 2, 2, 2, 0);
    chk("t3_err", 0, 32'(err8), 32'd1);
    chk("t3_nowe", 0, 32'(bus8.imem_we), 32'd0);
    beat(8, 3, 3, 3, 1);
    chk("t3_addr", 0, 32'(bus8.imem_addr), 32'd1);
    chk("t3_count", 0, 32'(count8), 32'd2);
    idle(2);
    chk("t3_mem0", 0, mem8[0], 32'h001080B3);
    chk("t3_mem1", 0, mem8[1], 32'h0031E1B3);

    // Overflow on the 4-word writer
    pulse_start();
    for (int i = 0; i < 4; i++) beat(0, i, i, i, 0);
    chk("t4_done", 1, 32'(done2), 32'd1);
    chk("t4_err", 1, 32'(err2), 32'd1);
    chk("t4_addr", 1, 32'(bus2.imem_addr), 32'd3);
    chk("t4_ready", 1, 32'(bus2.in_ready), 32'd0);
    beat(0, 4, 4, 4, 0);
    chk("t4_count", 1, 32'(count2), 32'd4);
    chk("t4_busy", 1, 32'(busy2), 32'd0);
    beat(0, 5, 5, 5, 1);
    idle(2);

    // Sparse valid with a stray start mid-load
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_alu_sel = 4'($urandom_range(0, 9));
      in_rd      = 5'($urandom_range(0, 31));
      in_rs1     = 5'($urandom_range(0, 31));
      in_rs2     = 5'($urandom_range(0, 31));
      in_last    = 1'b0;
      start      = (i == 7);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("t5_busy", 0, 32'(busy8), 32'd1);
    beat(3, 9, 9, 9, 1);
    idle(2);

    // Reset mid-load squashes the pending write
    pulse_start();
    beat(0, 1, 1, 1, 0);
    beat(5, 2, 2, 2, 0);
    beat(13, 3, 3, 3, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    chk("t6_we", 0, 32'(bus8.imem_we), 32'd0);
    chk("t6_busy", 0, 32'(busy8), 32'd0);
    chk("t6_count", 0, 32'(count8), 32'd0);
    chk("t6_err", 0, 32'(err8), 32'd0);
    rst_n = 1'b1;
    idle(1);
    pulse_start();
    beat(0, 7, 7, 7, 1);
    chk("t6_we2", 0, 32'(bus8.imem_we), 32'd1);
    chk("t6_addr2", 0, 32'(bus8.imem_addr), 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
